ad7643_dual_rx: RTL

//  Dual-channel AD7643 serial-slave readout engine. Paces conversions, drives shared CNVST/CS_N/SCLK,

---
 rtl/ad7643_pkg.sv | 21 ++
 rtl/ad_sync2.sv | 28 ++
 rtl/ad7643_dual_rx.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ad7643_pkg.sv
// ad7643_pkg
//  Shared definitions for the dual AD7643 readout engine: FSM state
//  encoding (also exported on fsm_st for monitoring), state width and the
//  default sample width.
//  No ports (package).
package ad7643_pkg;

  localparam int ST_W     = 3;
  localparam int DEF_BITS = 18;

  // Codes are visible on fsm_st, so the numeric values are part of the interface
  typedef enum logic [ST_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_CNV   = 3'd1,
    ST_WBUSY = 3'd2,
    ST_READ  = 3'd3,
    ST_PUSH  = 3'd4,
    ST_HOLD  = 3'd5
  } state_t;

endpackage

// File: rtl/ad_sync2.sv
// ad_sync2
//  Two-flop synchroniser for a single asynchronous level (BUSY / RDERR lines
//  from the ADCs). Output resets to 0.
//  Ports:
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset
//   d     in  asynchronous input level
//   q     out synchronised level (two clk cycles of latency)
module ad_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ad7643_dual_rx.sv
// ad7643_dual_rx
//  Dual-channel AD7643 serial-slave readout engine. Paces conversions every
//  PERIOD clocks, drives the shared cnvst/cs_n/sclk lines, shifts BITS-wide
//  samples from sdo0/sdo1 and hands each pair downstream via valid/ready.
//  Optional feature macro: ADC_RDERR_EN (adds rderr_flag output and drops
//  pairs whose RDERR line was set at the end of the read).
//  Ports:
//   clk        in   system clock, all logic on posedge
//   rst_n      in   asynchronous active-low reset
//   en         in   1 = acquire; 0 = finish current frame, then idle
//   cnvst      out  conversion start, both ADCs
//   cs_n       out  serial chip select, active low
//   sclk       out  serial clock, both ADCs
//   sdo0/sdo1  in   serial data, MSB first
//   busy0/1    in   ADC busy (asynchronous)
//   rderr0/1   in   ADC read error (only used with ADC_RDERR_EN)
//   dout0/1    out  sample pair
//   dvalid     out  dout0/dout1 valid
//   dready     in   consumer accepts when dvalid & dready
//   overrun    out  sticky: pair dropped because consumer was busy
//   timeout    out  sticky: BUSY never fell
//   fsm_st     out  current state code
//   rderr_flag out  sticky read-error flag (ADC_RDERR_EN only)
module ad7643_dual_rx
  import ad7643_pkg::*;
#(
  parameter int BITS     = DEF_BITS,
  parameter int PERIOD   = 250,
  parameter int CNV_HIGH = 4,
  parameter int CLK_DIV  = 2,
  parameter int BUSY_TMO = 200
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  output logic            cnvst,
  output logic            cs_n,
  output logic            sclk,
  input  logic            sdo0,
  input  logic            sdo1,
  input  logic            busy0,
  input  logic            busy1,
  input  logic            rderr0,
  input  logic            rderr1,
  output logic [BITS-1:0] dout0,
  output logic [BITS-1:0] dout1,
  output logic            dvalid,
  input  logic            dready,
  output logic            overrun,
  output logic            timeout,
  output logic [ST_W-1:0] fsm_st
`ifdef ADC_RDERR_EN
  ,
  output logic            rderr_flag
`endif
);

  localparam int PW = $clog2(PERIOD);
  localparam int CW = $clog2(BUSY_TMO + CNV_HIGH + 1);
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(BITS + 1);

  state_t          state;
  logic [PW-1:0]   pcnt;
  logic [CW-1:0]   cnt;
  logic [DW-1:0]   div_cnt;
  logic [BW-1:0]   bit_cnt;
  logic            seen_busy;
  logic            en_d;
  logic            sdo0_r, sdo1_r;
  logic [BITS-1:0] sh0, sh1;
  logic            busy0_s, busy1_s, busy_any;
  logic            en_rise;
  logic            push_ok;

  ad_sync2 u_sync_busy0 (.clk(clk), .rst_n(rst_n), .d(busy0), .q(busy0_s));
  ad_sync2 u_sync_busy1 (.clk(clk), .rst_n(rst_n), .d(busy1), .q(busy1_s));

  assign busy_any = busy0_s | busy1_s;
  assign en_rise  = en & ~en_d;
  assign fsm_st   = state;

`ifdef ADC_RDERR_EN
  logic rderr0_s, rderr1_s;

  ad_sync2 u_sync_rderr0 (.clk(clk), .rst_n(rst_n), .d(rderr0), .q(rderr0_s));
  ad_sync2 u_sync_rderr1 (.clk(clk), .rst_n(rst_n), .d(rderr1), .q(rderr1_s));

  assign push_ok = ~(rderr0_s | rderr1_s);
`else
  logic unused_rderr;

  assign unused_rderr = rderr0 | rderr1;
  assign push_ok      = 1'b1;
`endif

  // SDO lines are registered once so the shift always uses a clean sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sdo0_r <= 1'b0;
      sdo1_r <= 1'b0;
    end else begin
      sdo0_r <= sdo0;
      sdo1_r <= sdo1;
    end
  end

  // Period counter, FSM, SCLK divider, shifters and output registers.
  // pcnt restarts at 0 on every CNV entry so the HOLD exit lands exactly
  // PERIOD clocks after the previous CNVST rise; a frame that runs past
  // PERIOD simply waits for the following wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      pcnt      <= '0;
      cnt       <= '0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      seen_busy <= 1'b0;
      en_d      <= 1'b0;
      cnvst     <= 1'b0;
      cs_n      <= 1'b1;
      sclk      <= 1'b0;
      sh0       <= '0;
      sh1       <= '0;
      dout0     <= '0;
      dout1     <= '0;
      dvalid    <= 1'b0;
      overrun   <= 1'b0;
      timeout   <= 1'b0;
`ifdef ADC_RDERR_EN
      rderr_flag <= 1'b0;
`endif
    end else begin
      en_d <= en;

      if (state == ST_IDLE || pcnt == PW'(PERIOD - 1))
        pcnt <= '0;
      else
        pcnt <= pcnt + 1'b1;

      // Accepted data drops valid unless PUSH reloads it below
      if (dvalid && dready)
        dvalid <= 1'b0;

      if (en_rise) begin
        overrun <= 1'b0;
        timeout <= 1'b0;
`ifdef ADC_RDERR_EN
        rderr_flag <= 1'b0;
`endif
      end

      case (state)
        ST_IDLE: begin
          if (en) begin
            state <= ST_CNV;
            cnvst <= 1'b1;
            cnt   <= '0;
          end
        end

        ST_CNV: begin
          if (cnt == CW'(CNV_HIGH - 1)) begin
            cnvst     <= 1'b0;
            cnt       <= '0;
            seen_busy <= 1'b0;
            state     <= ST_WBUSY;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // Need to see BUSY high before its fall counts as end of conversion
        ST_WBUSY: begin
          if (busy_any)
            seen_busy <= 1'b1;
          if (seen_busy && !busy_any) begin
            cs_n    <= 1'b0;
            sclk    <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            state   <= ST_READ;
          end else if (cnt == CW'(BUSY_TMO - 1)) begin
            timeout <= 1'b1;
            state   <= ST_HOLD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // Each bit: CLK_DIV clocks low, CLK_DIV high; sample on the rising step
        ST_READ: begin
          if (div_cnt == DW'(CLK_DIV - 1)) begin
            div_cnt <= '0;
            if (!sclk) begin
              sclk <= 1'b1;
              sh0  <= {sh0[BITS-2:0], sdo0_r};
              sh1  <= {sh1[BITS-2:0], sdo1_r};
            end else begin
              sclk <= 1'b0;
              if (bit_cnt == BW'(BITS - 1)) begin
                cs_n  <= 1'b1;
                state <= ST_PUSH;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        ST_PUSH: begin
          if (!push_ok) begin
`ifdef ADC_RDERR_EN
            rderr_flag <= 1'b1;
`endif
          end else if (!dvalid || dready) begin
            dout0  <= sh0;
            dout1  <= sh1;
            dvalid <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
          state <= ST_HOLD;
        end

        ST_HOLD: begin
          if (pcnt == PW'(PERIOD - 1)) begin
            if (en) begin
              state <= ST_CNV;
              cnvst <= 1'b1;
              cnt   <= '0;
            end else begin
              state <= ST_IDLE;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
